// File: rtl/decode_pipe.sv
// Decode stage: register file with writeback bypass, RV32I immediate generation
// and a registered ID/EX stage with valid/ready handshake, flush and load-use interlock.
module decode_pipe #(
  parameter  int unsigned XLEN     = 32,
  parameter  int unsigned NUM_REGS = 32,
  localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_pc_inc,
  input  logic              i_flush,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [XLEN-1:0]   i_writeback,
  input  logic              i_ex_ready,
  output logic              o_decode_valid,
  output logic [31:0]       o_decode_inst,
  output logic [XLEN-1:0]   o_decode_pc,
  output logic [XLEN-1:0]   o_decode_pc_inc,
  output logic [XLEN-1:0]   o_decode_data_1,
  output logic [XLEN-1:0]   o_decode_data_2,
  output logic [XLEN-1:0]   o_decode_immediate,
  output logic [REG_AW-1:0] o_decode_rd,
  output logic              o_decode_reg_wr_en,
  output logic              o_decode_mem_read,
  output logic              o_decode_mem_write,
  output logic [2:0]        o_decode_load_store_mode,
  output logic              o_decode_illegal
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [XLEN-1:0]   rf [NUM_REGS];
  logic [6:0]        opcode;
  logic [4:0]        rd_f, rs1_f, rs2_f;
  logic [31:0]       imm32;
  logic              known, wr_rd, use1, use2, is_ld, is_st, bad_idx, illegal;
  logic              dec_wr_en, dec_mem_rd, dec_mem_wr;
  logic [2:0]        dec_mode;
  logic [XLEN-1:0]   imm_x, rdata1, rdata2;
  logic [REG_AW-1:0] rs1_idx, rs2_idx;
  logic              wb_hit, hazard, advance;

  assign opcode  = i_inst[6:0];
  assign rd_f    = i_inst[11:7];
  assign rs1_f   = i_inst[19:15];
  assign rs2_f   = i_inst[24:20];
  assign rs1_idx = rs1_f[REG_AW-1:0];
  assign rs2_idx = rs2_f[REG_AW-1:0];

  // Format decode: immediate layout and which register fields are live
  always_comb begin
    imm32 = '0;
    known = 1'b1;
    wr_rd = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    is_ld = 1'b0;
    is_st = 1'b0;
    case (opcode)
      OP_IMM, OP_JALR: begin
        imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        wr_rd = 1'b1;
        use1  = 1'b1;
      end
      OP_LOAD: begin
        imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        wr_rd = 1'b1;
        use1  = 1'b1;
        is_ld = 1'b1;
      end
      OP_STORE: begin
        imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        use1  = 1'b1;
        use2  = 1'b1;
        is_st = 1'b1;
      end
      OP_BRANCH: begin
        imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
        use1  = 1'b1;
        use2  = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm32 = {i_inst[31:12], 12'b0};
        wr_rd = 1'b1;
      end
      OP_JAL: begin
        imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
        wr_rd = 1'b1;
      end
      OP_REG: begin
        wr_rd = 1'b1;
        use1  = 1'b1;
        use2  = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // Register indices beyond the implemented file (RV32E) are illegal
  assign bad_idx = (wr_rd && (32'(rd_f)  >= NUM_REGS)) ||
                   (use1  && (32'(rs1_f) >= NUM_REGS)) ||
                   (use2  && (32'(rs2_f) >= NUM_REGS));
  assign illegal    = ~known | bad_idx;
  assign dec_wr_en  = wr_rd & (rd_f != 5'd0) & ~illegal;
  assign dec_mem_rd = is_ld & ~illegal;
  assign dec_mem_wr = is_st & ~illegal;
  assign dec_mode   = (dec_mem_rd | dec_mem_wr) ? i_inst[14:12] : 3'b000;
  assign imm_x      = XLEN'($signed(imm32));

  // Read ports with same-cycle writeback bypass
  assign wb_hit = i_wb_en && (i_wb_rd != '0);
  assign rdata1 = (rs1_f == 5'd0) ? '0 :
                  (wb_hit && (i_wb_rd == rs1_idx)) ? i_writeback : rf[rs1_idx];
  assign rdata2 = (rs2_f == 5'd0) ? '0 :
                  (wb_hit && (i_wb_rd == rs2_idx)) ? i_writeback : rf[rs2_idx];

  assign hazard = o_decode_valid & o_decode_mem_read & (o_decode_rd != '0) & i_valid &
                  ((use1 & (rs1_f == 5'(o_decode_rd))) | (use2 & (rs2_f == 5'(o_decode_rd))));
  assign advance = ~o_decode_valid | i_ex_ready;
  assign o_ready = advance & ~hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[i_wb_rd] <= i_writeback;
    end
  end

  // ID/EX register: flush beats advance beats stall; a stalled entry snoops writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_decode_valid           <= 1'b0;
      o_decode_inst            <= '0;
      o_decode_pc              <= '0;
      o_decode_pc_inc          <= '0;
      o_decode_data_1          <= '0;
      o_decode_data_2          <= '0;
      o_decode_immediate       <= '0;
      o_decode_rd              <= '0;
      o_decode_reg_wr_en       <= 1'b0;
      o_decode_mem_read        <= 1'b0;
      o_decode_mem_write       <= 1'b0;
      o_decode_load_store_mode <= '0;
      o_decode_illegal         <= 1'b0;
    end else if (i_flush) begin
      o_decode_valid <= 1'b0;
    end else if (advance) begin
      if (i_valid && !hazard) begin
        o_decode_valid           <= 1'b1;
        o_decode_inst            <= i_inst;
        o_decode_pc              <= i_pc;
        o_decode_pc_inc          <= i_pc_inc;
        o_decode_data_1          <= rdata1;
        o_decode_data_2          <= rdata2;
        o_decode_immediate       <= imm_x;
        o_decode_rd              <= rd_f[REG_AW-1:0];
        o_decode_reg_wr_en       <= dec_wr_en;
        o_decode_mem_read        <= dec_mem_rd;
        o_decode_mem_write       <= dec_mem_wr;
        o_decode_load_store_mode <= dec_mode;
        o_decode_illegal         <= illegal;
      end else begin
        o_decode_valid <= 1'b0;
      end
    end else if (wb_hit) begin
      if (5'(i_wb_rd) == o_decode_inst[19:15]) o_decode_data_1 <= i_writeback;
      if (5'(i_wb_rd) == o_decode_inst[24:20]) o_decode_data_2 <= i_writeback;
    end
  end
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed RV32I instruction stream checked every cycle
// against an instruction-level model, plus hand-computed literal expectations.
module tb_decode_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_flush, i_wb_en, i_ex_ready;
  logic [31:0] i_inst, i_pc, i_pc_inc, i_writeback;
  logic [4:0]  i_wb_rd;

  logic        o_ready, o_decode_valid, o_decode_reg_wr_en, o_decode_mem_read;
  logic        o_decode_mem_write, o_decode_illegal;
  logic [31:0] o_decode_inst, o_decode_pc, o_decode_pc_inc, o_decode_data_1;
  logic [31:0] o_decode_data_2, o_decode_immediate;
  logic [4:0]  o_decode_rd;
  logic [2:0]  o_decode_load_store_mode;

  logic        r16_ready, r16_valid, r16_wr_en, r16_mem_read, r16_mem_write, r16_illegal;
  logic [31:0] r16_inst, r16_pc, r16_pc_inc, r16_data_1, r16_data_2, r16_imm;
  logic [3:0]  r16_rd;
  logic [2:0]  r16_mode;

  int checks = 0;
  int failures = 0;
  logic [31:0] pc = 32'h100;

  always #5 clk = ~clk;

  decode_pipe dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst),
    .i_pc(i_pc), .i_pc_inc(i_pc_inc), .i_flush(i_flush), .i_wb_en(i_wb_en),
    .i_wb_rd(i_wb_rd), .i_writeback(i_writeback), .i_ex_ready(i_ex_ready),
    .o_decode_valid(o_decode_valid), .o_decode_inst(o_decode_inst),
    .o_decode_pc(o_decode_pc), .o_decode_pc_inc(o_decode_pc_inc),
    .o_decode_data_1(o_decode_data_1), .o_decode_data_2(o_decode_data_2),
    .o_decode_immediate(o_decode_immediate), .o_decode_rd(o_decode_rd),
    .o_decode_reg_wr_en(o_decode_reg_wr_en), .o_decode_mem_read(o_decode_mem_read),
    .o_decode_mem_write(o_decode_mem_write),
    .o_decode_load_store_mode(o_decode_load_store_mode), .o_decode_illegal(o_decode_illegal)
  );

  decode_pipe #(.NUM_REGS(16)) dut16 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(r16_ready), .i_inst(i_inst),
    .i_pc(i_pc), .i_pc_inc(i_pc_inc), .i_flush(i_flush), .i_wb_en(i_wb_en),
    .i_wb_rd(i_wb_rd[3:0]), .i_writeback(i_writeback), .i_ex_ready(i_ex_ready),
    .o_decode_valid(r16_valid), .o_decode_inst(r16_inst),
    .o_decode_pc(r16_pc), .o_decode_pc_inc(r16_pc_inc),
    .o_decode_data_1(r16_data_1), .o_decode_data_2(r16_data_2),
    .o_decode_immediate(r16_imm), .o_decode_rd(r16_rd),
    .o_decode_reg_wr_en(r16_wr_en), .o_decode_mem_read(r16_mem_read),
    .o_decode_mem_write(r16_mem_write),
    .o_decode_load_store_mode(r16_mode), .o_decode_illegal(r16_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] inst, pc, pc_inc, d1, d2, imm;
    logic [4:0]  rd;
    logic        wr, mr, mw;
    logic [2:0]  mode;
    logic        ill;
  } exp_t;

  exp_t        e;
  logic [31:0] mrf [32];

  function automatic bit uses_rs1(input logic [31:0] inst);
    case (inst[6:0])
      7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h67: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit uses_rs2(input logic [31:0] inst);
    case (inst[6:0])
      7'h33, 7'h23, 7'h63: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writes_rd(input logic [31:0] inst);
    case (inst[6:0])
      7'h33, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h6F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] inst);
    int s;
    s = int'(inst);
    case (inst[6:0])
      7'h13, 7'h03, 7'h67: return 32'(s >>> 20);
      7'h23: return 32'((s >>> 25) * 32 + int'(inst[11:7]));
      7'h63: return 32'((s >>> 31) * 4096 + int'(inst[7]) * 2048 +
                        int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2);
      7'h37, 7'h17: return 32'(s) & 32'hFFFF_F000;
      7'h6F: return 32'((s >>> 31) * 1048576 + int'(inst[19:12]) * 4096 +
                        int'(inst[20]) * 2048 + int'(inst[30:21]) * 2);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (i_wb_en && i_wb_rd != 5'd0 && i_wb_rd == idx) return i_writeback;
    return mrf[idx];
  endfunction

  function automatic bit model_hazard();
    if (!(e.valid && e.mr && e.rd != 5'd0 && i_valid)) return 1'b0;
    return (uses_rs1(i_inst) && i_inst[19:15] == e.rd) ||
           (uses_rs2(i_inst) && i_inst[24:20] == e.rd);
  endfunction

  function automatic exp_t next_e();
    exp_t n;
    n = e;
    if (i_flush) begin
      n.valid = 1'b0;
    end else if (!e.valid || i_ex_ready) begin
      if (i_valid && !model_hazard()) begin
        n.valid  = 1'b1;
        n.inst   = i_inst;
        n.pc     = i_pc;
        n.pc_inc = i_pc_inc;
        n.d1     = read_reg(i_inst[19:15]);
        n.d2     = read_reg(i_inst[24:20]);
        n.ill    = !(uses_rs1(i_inst) || writes_rd(i_inst));
        n.imm    = imm_of(i_inst);
        n.rd     = i_inst[11:7];
        n.wr     = writes_rd(i_inst) && i_inst[11:7] != 5'd0 && !n.ill;
        n.mr     = i_inst[6:0] == 7'h03;
        n.mw     = i_inst[6:0] == 7'h23;
        n.mode   = (n.mr || n.mw) ? i_inst[14:12] : 3'd0;
      end else begin
        n.valid = 1'b0;
      end
    end else if (i_wb_en && i_wb_rd != 5'd0) begin
      if (i_wb_rd == e.inst[19:15]) n.d1 = i_writeback;
      if (i_wb_rd == e.inst[24:20]) n.d2 = i_writeback;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e <= '0;
      for (int i = 0; i < 32; i++) mrf[i] <= 32'h0;
    end else begin
      e <= next_e();
      if (i_wb_en && i_wb_rd != 5'd0) mrf[i_wb_rd] <= i_writeback;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ready", 32'(o_ready), 32'((!e.valid || i_ex_ready) && !model_hazard()));
    chk("valid", 32'(o_decode_valid), 32'(e.valid));
    if (e.valid) begin
      chk("inst", o_decode_inst, e.inst);
      chk("pc", o_decode_pc, e.pc);
      chk("pc_inc", o_decode_pc_inc, e.pc_inc);
      chk("data_1", o_decode_data_1, e.d1);
      chk("data_2", o_decode_data_2, e.d2);
      chk("imm", o_decode_immediate, e.imm);
      chk("rd", 32'(o_decode_rd), 32'(e.rd));
      chk("wr_en", 32'(o_decode_reg_wr_en), 32'(e.wr));
      chk("mem_rd", 32'(o_decode_mem_read), 32'(e.mr));
      chk("mem_wr", 32'(o_decode_mem_write), 32'(e.mw));
      chk("ls_mode", 32'(o_decode_load_store_mode), 32'(e.mode));
      chk("illegal", 32'(o_decode_illegal), 32'(e.ill));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic wb_en,
                       input logic [4:0] wb_rd, input logic [31:0] wb);
    i_valid     = v;
    i_inst      = inst;
    i_pc        = pc;
    i_pc_inc    = pc + 32'd4;
    pc          = pc + 32'd4;
    i_wb_en     = wb_en;
    i_wb_rd     = wb_rd;
    i_writeback = wb;
    #1;
  endtask

  initial begin
    reset = 1'b0; i_valid = 1'b0; i_inst = '0; i_pc = '0; i_pc_inc = '0;
    i_flush = 1'b0; i_wb_en = 1'b0; i_wb_rd = '0; i_writeback = '0; i_ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_decode_valid), 32'h0);
    chk("rst_imm", o_decode_immediate, 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h1);
    reset = 1'b1;

    drive(1, 32'h00400793, 0, 0, 0); step();              // addi x15,x0,4
    chk("addi_valid", 32'(o_decode_valid), 32'h1);
    chk("addi_rd", 32'(o_decode_rd), 32'd15);
    chk("addi_imm", o_decode_immediate, 32'h4);
    chk("addi_wr", 32'(o_decode_reg_wr_en), 32'h1);
    chk("addi_d1", o_decode_data_1, 32'h0);

    drive(1, 32'hFFF00093, 1, 5'd15, 32'd4); step();      // addi x1,x0,-1 ; x15=4
    chk("neg_imm", o_decode_immediate, 32'hFFFF_FFFF);

    drive(1, 32'hFE000EE3, 0, 0, 0); step();              // beq x0,x0,-4
    chk("beq_imm", o_decode_immediate, 32'hFFFF_FFFC);
    chk("beq_wr", 32'(o_decode_reg_wr_en), 32'h0);

    drive(1, 32'h40F50533, 1, 5'd10, 32'd5); step();      // sub x10,x10,x15 ; bypass x10=5
    chk("byp_d1", o_decode_data_1, 32'd5);
    chk("byp_d2", o_decode_data_2, 32'd4);

    drive(1, 32'h00052283, 0, 0, 0); step();              // lw x5,0(x10)
    chk("lw_mrd", 32'(o_decode_mem_read), 32'h1);
    chk("lw_mode", 32'(o_decode_load_store_mode), 32'd2);

    drive(1, 32'h00528333, 0, 0, 0);                      // add x6,x5,x5 : load-use
    chk("lu_ready0", 32'(o_ready), 32'h0);
    step();
    chk("lu_bubble", 32'(o_decode_valid), 32'h0);
    chk("lu_ready1", 32'(o_ready), 32'h1);
    step();
    chk("lu_issue", 32'(o_decode_valid), 32'h1);
    chk("lu_inst", o_decode_inst, 32'h00528333);

    i_ex_ready = 1'b0;                                    // stall and snoop x5
    drive(0, 32'h0, 1, 5'd5, 32'h1234);
    chk("stall_ready", 32'(o_ready), 32'h0);
    step();
    chk("snoop_valid", 32'(o_decode_valid), 32'h1);
    chk("snoop_d1", o_decode_data_1, 32'h1234);
    chk("snoop_d2", o_decode_data_2, 32'h1234);

    i_flush = 1'b1;
    drive(1, 32'h00100093, 0, 0, 0); step();
    chk("flush_valid", 32'(o_decode_valid), 32'h0);
    i_flush = 1'b0;
    i_ex_ready = 1'b1;

    drive(1, 32'h000003B3, 1, 5'd0, 32'hDEAD); step();    // add x7,x0,x0 ; write x0
    chk("x0_byp", o_decode_data_1, 32'h0);
    drive(1, 32'h000003B3, 0, 0, 0); step();
    chk("x0_read", o_decode_data_2, 32'h0);

    drive(1, 32'h00100A13, 0, 0, 0); step();              // addi x20,x0,1
    chk("rv32i_ill", 32'(o_decode_illegal), 32'h0);
    chk("rv32e_valid", 32'(r16_valid), 32'h1);
    chk("rv32e_ill", 32'(r16_illegal), 32'h1);
    chk("rv32e_wr", 32'(r16_wr_en), 32'h0);

    drive(1, 32'hFFFFFFFF, 0, 0, 0); step();              // unknown opcode
    chk("bad_ill", 32'(o_decode_illegal), 32'h1);
    chk("bad_imm", o_decode_immediate, 32'h0);

    drive(1, 32'h008000EF, 0, 0, 0); step();              // jal x1,8
    chk("jal_imm", o_decode_immediate, 32'd8);
    drive(1, 32'h123452B7, 0, 0, 0); step();              // lui x5,0x12345
    chk("lui_imm", o_decode_immediate, 32'h12345000);
    drive(1, 32'hFE552E23, 0, 0, 0); step();              // sw x5,-4(x10)
    chk("sw_imm", o_decode_immediate, 32'hFFFF_FFFC);
    chk("sw_mwr", 32'(o_decode_mem_write), 32'h1);
    chk("sw_d2", o_decode_data_2, 32'h1234);

    i_ex_ready = 1'b0;                                    // reset in the middle of a stall
    drive(0, 32'h0, 0, 0, 0); step();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_decode_valid), 32'h0);
    step();
    reset = 1'b1;
    i_ex_ready = 1'b1;
    drive(1, 32'h00528333, 0, 0, 0); step();
    chk("rf_lost", o_decode_data_1, 32'h0);
    drive(0, 32'h0, 0, 0, 0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
